// File: rtl/hs32_pkg.sv
// Shared definitions for the HS32 fetch stage: word width, PC step,
// default reset vector, fetch FSM encoding and the buffered word layout.
package hs32_pkg;

   localparam int                WORD_W            = 32;
   localparam logic [WORD_W-1:0] PC_INC            = 32'd4;
   localparam logic [WORD_W-1:0] DEFAULT_RESET_VEC = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,
      FETCH_REQ  = 2'd1,
      FETCH_DROP = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [WORD_W-1:0] inst;
      logic [WORD_W-1:0] pc;
   } fetch_word_t;

   localparam int FETCH_WORD_W = $bits(fetch_word_t);

   // Sequential PC step; wraps modulo 2^32 through plain unsigned overflow.
   function automatic logic [WORD_W-1:0] next_seq_pc(input logic [WORD_W-1:0] pc);
      return pc + PC_INC;
   endfunction

endpackage

// File: rtl/hs32_fifo.sv
// Synchronous FIFO with push, pop and flush; the head entry is visible on dout
// without a read strobe. DEPTH must be a power of two, >= 2.
module hs32_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;
   logic [WIDTH-1:0] entries [DEPTH];

   assign empty = (count_reg == '0);
   assign full  = (count_reg == (AW+1)'(DEPTH));
   assign count = count_reg;

   // A push into a full FIFO is accepted when the head leaves in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [WIDTH-1:0] entry_reg;

         always_ff @(posedge clk) begin
            if (reset) begin
               entry_reg <= '0;
            end else if (do_push && (wr_ptr_reg == AW'(gi))) begin
               entry_reg <= din;
            end
         end

         assign entries[gi] = entry_reg;
      end
   endgenerate

   assign dout = entries[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/hs32_fetch.sv
// HS32 instruction fetch: PC, arbiter request FSM and decode-side buffer.
// Define HS32_FETCH_PREFETCH_EN for a DEPTH-entry prefetch FIFO; otherwise one output register.
module hs32_fetch
   import hs32_pkg::*;
#(
   parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC,
   parameter int          DEPTH     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] newpc,
   input  logic        flush,
   output logic [31:0] addr,
   output logic        reqm,
   input  logic [31:0] dtrm,
   input  logic        ackm,
   output logic [31:0] instd,
   output logic [31:0] pcd,
   output logic        valid,
   input  logic        ready
);

   fetch_state_t state_reg;
   logic [31:0]  pc_reg;
   logic [31:0]  addr_reg;
   logic         reqm_reg;

   logic         push;
   logic         pop;
   logic         slot_free;
   logic         req_slot_open;
   logic         issue;
   logic [31:0]  pc_next;

   assign pop  = valid && ready;
   assign push = (state_reg == FETCH_REQ) && ackm && !flush;

   assign pc_next = flush ? newpc : (push ? next_seq_pc(pc_reg) : pc_reg);

   // The arbiter port is free when idle or when the outstanding request
   // completes this cycle, so a new request can follow an ack immediately.
   assign req_slot_open = (state_reg == FETCH_IDLE) || ackm;
   assign issue         = req_slot_open && (flush || slot_free);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= FETCH_IDLE;
         pc_reg    <= RESET_VEC;
         addr_reg  <= '0;
         reqm_reg  <= 1'b0;
      end else begin
         pc_reg <= pc_next;
         case (state_reg)
            FETCH_IDLE: begin
               if (issue) begin
                  state_reg <= FETCH_REQ;
                  addr_reg  <= pc_next;
                  reqm_reg  <= 1'b1;
               end
            end
            FETCH_REQ, FETCH_DROP: begin
               if (ackm) begin
                  if (issue) begin
                     state_reg <= FETCH_REQ;
                     addr_reg  <= pc_next;
                     reqm_reg  <= 1'b1;
                  end else begin
                     state_reg <= FETCH_IDLE;
                     reqm_reg  <= 1'b0;
                  end
               end else if (flush) begin
                  // The arbiter cannot abort, so addr/reqm stay held and the data is discarded.
                  state_reg <= FETCH_DROP;
               end
            end
            default: begin
               state_reg <= FETCH_IDLE;
               reqm_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign addr = addr_reg;
   assign reqm = reqm_reg;

`ifdef HS32_FETCH_PREFETCH_EN

   localparam int AW = $clog2(DEPTH);

   fetch_word_t fifo_din;
   fetch_word_t fifo_dout;
   logic        fifo_full;
   logic        fifo_empty;
   logic [AW:0] fifo_count;

   assign fifo_din = '{inst: dtrm, pc: addr_reg};

   // Occupancy after this cycle's push/pop must leave room for one more word.
   always_comb begin
      slot_free = 1'b0;
      if (!push) begin
         slot_free = !fifo_full || pop;
      end else if (pop) begin
         slot_free = !fifo_full;
      end else begin
         slot_free = (fifo_count < (AW+1)'(DEPTH - 1));
      end
   end

   hs32_fifo #(
      .WIDTH (FETCH_WORD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign instd = fifo_dout.inst;
   assign pcd   = fifo_dout.pc;
   assign valid = !fifo_empty;

`else

   logic        valid_reg;
   logic [31:0] instd_reg;
   logic [31:0] pcd_reg;
   logic        unused_depth_ok;

   assign unused_depth_ok = (DEPTH >= 2);

   // A word landing this cycle occupies the register, even if the old one is popped.
   assign slot_free = !push && (!valid_reg || pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_reg <= 1'b0;
         instd_reg <= '0;
         pcd_reg   <= '0;
      end else if (flush) begin
         valid_reg <= 1'b0;
      end else if (push) begin
         valid_reg <= 1'b1;
         instd_reg <= dtrm;
         pcd_reg   <= addr_reg;
      end else if (pop) begin
         valid_reg <= 1'b0;
      end
   end

   assign instd = instd_reg;
   assign pcd   = pcd_reg;
   assign valid = valid_reg;

`endif

endmodule

// File: tb/tb_hs32_fetch.sv
// Directed bench for hs32_fetch: stream, backpressure, redirects, wrap and reset.
// Buffer size expectations follow HS32_FETCH_PREFETCH_EN.
module tb_hs32_fetch;

`ifdef HS32_FETCH_PREFETCH_EN
   localparam int BUF_WORDS = 2;
`else
   localparam int BUF_WORDS = 1;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] newpc;
   logic        flush;
   logic [31:0] addr;
   logic        reqm;
   logic [31:0] dtrm;
   logic        ackm;
   logic [31:0] instd;
   logic [31:0] pcd;
   logic        valid;
   logic        ready;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] rx_pc[$];
   logic [31:0] rx_inst[$];
   bit          auto_arb;
   int          arb_lat;
   int          arb_cnt;
   int          base;
   logic [31:0] held;

   always #5 clk = ~clk;

   hs32_fetch #(
      .RESET_VEC (32'h0000_0000),
      .DEPTH     (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .newpc (newpc),
      .flush (flush),
      .addr  (addr),
      .reqm  (reqm),
      .dtrm  (dtrm),
      .ackm  (ackm),
      .instd (instd),
      .pcd   (pcd),
      .valid (valid),
      .ready (ready)
   );

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   // One clock: log a decode pop, advance past the edge, then run the arbiter model.
   task automatic step();
      if (valid && ready) begin
         rx_pc.push_back(pcd);
         rx_inst.push_back(instd);
         $display("rx   pc=%h inst=%h", pcd, instd);
      end
      @(posedge clk);
      #1;
      if (auto_arb && reqm) begin
         if (arb_cnt == arb_lat) begin
            ackm    = 1'b1;
            dtrm    = word_at(addr);
            arb_cnt = 0;
         end else begin
            ackm = 1'b0;
            arb_cnt++;
         end
      end else begin
         ackm    = 1'b0;
         arb_cnt = 0;
      end
   endtask

   initial begin
      reset    = 1'b1;
      flush    = 1'b0;
      ackm     = 1'b0;
      ready    = 1'b0;
      newpc    = '0;
      dtrm     = '0;
      auto_arb = 1'b0;
      arb_lat  = 2;
      arb_cnt  = 0;

      repeat (3) step();
      check_eq("rst_reqm",  {31'd0, reqm},  32'd0);
      check_eq("rst_addr",  addr,           32'd0);
      check_eq("rst_valid", {31'd0, valid}, 32'd0);
      check_eq("rst_instd", instd,          32'd0);
      check_eq("rst_pcd",   pcd,            32'd0);

      reset    = 1'b0;
      auto_arb = 1'b1;
      ready    = 1'b1;
      step();
      check_eq("first_reqm", {31'd0, reqm}, 32'd1);
      check_eq("first_addr", addr,          32'h0000_0000);

      // Basic stream: ack 2 cycles after each request, decode always ready.
      for (int i = 0; i < 60 && rx_pc.size() < 4; i++) step();
      check_eq("basic_count", rx_pc.size(), 32'd4);
      for (int k = 0; k < rx_pc.size(); k++) begin
         check_eq($sformatf("basic_pc%0d", k),   rx_pc[k],   32'(4 * k));
         check_eq($sformatf("basic_inst%0d", k), rx_inst[k], word_at(32'(4 * k)));
      end

      // Backpressure: buffer fills, fetch stops, head holds steady.
      ready = 1'b0;
      repeat (10) step();
      check_eq("bp_reqm",  {31'd0, reqm},  32'd0);
      check_eq("bp_valid", {31'd0, valid}, 32'd1);
      check_eq("bp_pcd",   pcd,            32'h10);
      check_eq("bp_instd", instd,          word_at(32'h10));

      auto_arb = 1'b0;
      ackm     = 1'b0;
      ready    = 1'b1;
      base     = rx_pc.size();
      repeat (6) step();
      check_eq("bp_drained", 32'(rx_pc.size() - base), 32'(BUF_WORDS));
      if (rx_pc.size() > base) begin
         check_eq("bp_first_pc", rx_pc[base],              32'h10);
         check_eq("bp_last_pc",  rx_pc[rx_pc.size() - 1], 32'(32'h10 + 4 * (BUF_WORDS - 1)));
      end
      held = 32'(32'h10 + 4 * BUF_WORDS);
      check_eq("bp_next_reqm",  {31'd0, reqm},  32'd1);
      check_eq("bp_next_addr",  addr,           held);
      check_eq("bp_next_valid", {31'd0, valid}, 32'd0);

      // Redirect while a request is outstanding; ack arrives 3 cycles later.
      newpc = 32'h100;
      flush = 1'b1;
      step();
      flush = 1'b0;
      check_eq("drop_reqm_held", {31'd0, reqm},  32'd1);
      check_eq("drop_addr_held", addr,           held);
      check_eq("drop_valid",     {31'd0, valid}, 32'd0);
      step();
      step();
      ackm = 1'b1;
      dtrm = word_at(held);
      step();
      ackm = 1'b0;
      check_eq("redir_reqm",  {31'd0, reqm},  32'd1);
      check_eq("redir_addr",  addr,           32'h100);
      check_eq("redir_valid", {31'd0, valid}, 32'd0);

      base     = rx_pc.size();
      auto_arb = 1'b1;
      for (int i = 0; i < 30 && rx_pc.size() == base; i++) step();
      auto_arb = 1'b0;
      ackm     = 1'b0;
      check_eq("redir_rx_count", 32'(rx_pc.size() - base), 32'd1);
      if (rx_pc.size() > base) begin
         check_eq("redir_rx_pc",   rx_pc[base],   32'h100);
         check_eq("redir_rx_inst", rx_inst[base], word_at(32'h100));
      end
      for (int i = 0; i < 10 && !reqm; i++) step();
      check_eq("redir_next_addr", addr, 32'h104);

      // Same-cycle flush and ack: data dropped, new request next cycle.
      newpc = 32'h200;
      flush = 1'b1;
      ackm  = 1'b1;
      dtrm  = 32'hDEAD_BEEF;
      step();
      flush = 1'b0;
      ackm  = 1'b0;
      check_eq("fa_reqm",  {31'd0, reqm},  32'd1);
      check_eq("fa_addr",  addr,           32'h200);
      check_eq("fa_valid", {31'd0, valid}, 32'd0);

      newpc = 32'hFFFF_FFFC;
      flush = 1'b1;
      ackm  = 1'b1;
      dtrm  = 32'hDEAD_BEEF;
      step();
      flush = 1'b0;
      ackm  = 1'b0;
      check_eq("wrap_req_addr", addr, 32'hFFFF_FFFC);

      // Kept ack at the top of the address space, then the PC wraps to 0.
      ready = 1'b0;
      ackm  = 1'b1;
      dtrm  = word_at(32'hFFFF_FFFC);
      step();
      ackm = 1'b0;
      check_eq("wrap_valid", {31'd0, valid}, 32'd1);
      check_eq("wrap_pcd",   pcd,            32'hFFFF_FFFC);
      check_eq("wrap_instd", instd,          32'hC0DE_FFFC);

      ready = 1'b1;
      for (int i = 0; i < 10 && !reqm; i++) step();
      check_eq("wrap_addr", addr, 32'h0000_0000);
      ackm = 1'b1;
      dtrm = word_at(32'h0);
      step();
      ackm = 1'b0;
      for (int i = 0; i < 10 && !reqm; i++) step();
      check_eq("post_wrap_addr", addr, 32'h0000_0004);

      // Reset in the middle of an outstanding request.
      reset = 1'b1;
      step();
      check_eq("mid_rst_reqm",  {31'd0, reqm},  32'd0);
      check_eq("mid_rst_addr",  addr,           32'd0);
      check_eq("mid_rst_valid", {31'd0, valid}, 32'd0);
      check_eq("mid_rst_instd", instd,          32'd0);
      check_eq("mid_rst_pcd",   pcd,            32'd0);
      reset = 1'b0;
      step();
      check_eq("restart_reqm", {31'd0, reqm}, 32'd1);
      check_eq("restart_addr", addr,          32'h0000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
